decode_operand_stage: RTL and testbench
=======================================

# decode_operand_stage

Decode-side operand stage of the pipeline: drives the register file read addresses, collects the two read operands with write-back bypass and $zero forcing, and latches them with pre-decoded control into the ID/EX pipeline register. It sits between IF/ID and the execute stage and runs a valid/ready handshake on both sides. A load-use interlock inserts a configurable number of bubbles behind loads.

## Interface
- N, 32: data width; register count is also N, so address width is $clog2(N).
- LOAD_BUBBLES, 1: minimum empty output cycles between a load leaving and a dependent instruction; legal range 1..4.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous kill of the held instruction and interlock state.
- InValid / InReady  in / out  1 / 1  upstream handshake.
- RsAddr, RtAddr, DestAddrIn  in  $clog2(N)  source and destination register numbers.
- RegWriteIn, MemReadIn  in  1  pre-decoded control bits.
- ImmIn  in  N  sign-extended immediate.
- Address1, Address2  out  $clog2(N)  register file read addresses; combinationally equal to RsAddr and RtAddr.
- ReadData1, ReadData2  in  N  register file read data.
- WbWriteEnable, WbAddress, WbData  in  1 / $clog2(N) / N  snoop of the register file write port.
- OutValid / OutReady  out / in  1 / 1  downstream handshake.
- OperandA, OperandB, ImmOut  out  N  latched operands and immediate.
- DestAddrOut  out  $clog2(N)  latched destination register number.
- RegWriteOut, MemReadOut  out  1  latched control bits.

## Operation
- Operand select for A, in priority order:
  - RsAddr==0 gives 0; the register file does not hard-wire $zero.
  - Otherwise, if WbWriteEnable and WbAddress==RsAddr, take WbData. This bypass is needed because the register file returns the old value in the cycle it is written.
  - Otherwise take ReadData1.
- Operand B is selected the same way using RtAddr and ReadData2.
- Accept = InValid & InReady. On accept, all output registers load and OutValid is set.
- The output registers hold while OutValid & ~OutReady.
- OutValid clears when the output is accepted downstream and no new input is accepted in the same cycle.
- InReady = Flush | ((~OutValid | OutReady) & ~Hazard).
- Hazard is true if either condition holds:
  - Output load: OutValid & MemReadOut & DestAddrOut!=0 & (DestAddrOut==RsAddr | DestAddrOut==RtAddr).
  - Interlock: State==INTERLOCK & (LdDest==RsAddr | LdDest==RtAddr).
- Interlock FSM:
  - RUN: when OutValid & OutReady & MemReadOut & DestAddrOut!=0, set LdDest<=DestAddrOut and LdCount<=LOAD_BUBBLES-1. Move to INTERLOCK if LOAD_BUBBLES>1; otherwise stay in RUN.
  - INTERLOCK: LdCount decrements every cycle. Move to RUN in the cycle LdCount==1.
  - A second load departing while in INTERLOCK reloads LdDest and LdCount.
- Flush, same edge:
  - OutValid<=0, State<=RUN, LdCount<=0.
  - An input presented in that cycle is accepted and discarded.
  - Flush has priority over capture and over OutReady.

## Timing
- Latency: an instruction accepted at edge k appears on the outputs after edge k and stays until OutReady.
- Full throughput: with no hazard, one instruction per cycle.
- Reset values: OutValid=0, OperandA=OperandB=ImmOut=0, DestAddrOut=0, RegWriteOut=MemReadOut=0, State=RUN, LdCount=0, LdDest=0.
  - InReady is therefore 1 out of reset.
- Reset mid-operation empties the stage immediately and asynchronously.
- Back-to-back loads to the same register each interlock independently.
- A bypass hit on $zero is ignored: the result is 0.

## Structure
- Shared package holds:
  - the interlock_state_t enum {RUN, INTERLOCK};
  - REG_ZERO;
  - the LOAD_BUBBLES bounds.
- Sub-module load_interlock holds the FSM, LdDest and LdCount, and produces Hazard.
- Operand muxing and the pipeline register stay in the top level.

## Test plan
- Reset release, then InValid=1, RsAddr=3, RtAddr=4, ReadData1=0x11, ReadData2=0x22, OutReady=1 -> the next cycle shows OutValid=1, OperandA=0x11, OperandB=0x22.
- RsAddr=0 with ReadData1=0xDEAD, and WbWriteEnable=1, WbAddress=0 -> OperandA=0.
- Same-cycle write-back: WbWriteEnable=1, WbAddress=5, WbData=0x55, RtAddr=5, ReadData2=0x99 -> OperandB=0x55.
- OutReady=0 for 3 cycles with InValid=1 -> InReady=0; outputs and OperandA stay stable; no input is lost when OutReady rises.
- LOAD_BUBBLES=2, a load to $7 followed by an instruction with RsAddr=7 -> exactly 2 cycles of OutValid=0 between them.
  - With RsAddr=8 instead -> no bubble.
- Flush while a stalled load is held and INTERLOCK is active -> the next cycle shows OutValid=0, State=RUN, InReady=1.

Source files
------------

// File: rtl/decode_operand_stage_pkg.sv
// Shared types and constants for the decode operand stage and its load interlock.
package decode_operand_stage_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    INTERLOCK = 1'b1
  } interlock_state_t;

  localparam int unsigned REG_ZERO         = 0;
  localparam int unsigned LOAD_BUBBLES_MIN = 1;
  localparam int unsigned LOAD_BUBBLES_MAX = 4;
  // Wide enough to hold LOAD_BUBBLES_MAX-1.
  localparam int unsigned LD_COUNT_W       = $clog2(LOAD_BUBBLES_MAX);

endpackage

// File: rtl/decode_operand_stage_load_interlock.sv
// Load-use interlock: tracks the last departed load and stalls dependent instructions.
module load_interlock
  import decode_operand_stage_pkg::*;
#(
  parameter int unsigned AW           = 5,
  parameter int unsigned LOAD_BUBBLES = 1
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          Flush,
  input  logic          OutValid,
  input  logic          OutReady,
  input  logic          MemReadOut,
  input  logic [AW-1:0] DestAddrOut,
  input  logic [AW-1:0] RsAddr,
  input  logic [AW-1:0] RtAddr,
  output logic          Hazard
);

  localparam logic [LD_COUNT_W-1:0] LD_INIT = LD_COUNT_W'(LOAD_BUBBLES - 1);

  interlock_state_t      state, state_nxt;
  logic [AW-1:0]         ld_dest, ld_dest_nxt;
  logic [LD_COUNT_W-1:0] ld_count, ld_count_nxt;
  logic                  out_is_load;
  logic                  load_departs;

  assign out_is_load  = OutValid & MemReadOut & (DestAddrOut != AW'(REG_ZERO));
  assign load_departs = out_is_load & OutReady;

  assign Hazard = (out_is_load & ((DestAddrOut == RsAddr) | (DestAddrOut == RtAddr)))
                | ((state == INTERLOCK) & ((ld_dest == RsAddr) | (ld_dest == RtAddr)));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= RUN;
      ld_dest  <= '0;
      ld_count <= '0;
    end else begin
      state    <= state_nxt;
      ld_dest  <= ld_dest_nxt;
      ld_count <= ld_count_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ld_dest_nxt  = ld_dest;
    ld_count_nxt = ld_count;
    if (Flush) begin
      state_nxt    = RUN;
      ld_count_nxt = '0;
    end else if (load_departs) begin
      // A departing load restarts the window even if one is already open.
      ld_dest_nxt  = DestAddrOut;
      ld_count_nxt = LD_INIT;
      state_nxt    = (LOAD_BUBBLES > 1) ? INTERLOCK : RUN;
    end else if (state == INTERLOCK) begin
      ld_count_nxt = ld_count - LD_COUNT_W'(1);
      if (ld_count == LD_COUNT_W'(1)) state_nxt = RUN;
    end
  end

endmodule

// File: rtl/decode_operand_stage.sv
// Decode operand stage: register-file read, write-back bypass, $zero forcing and ID/EX register.
module decode_operand_stage
  import decode_operand_stage_pkg::*;
#(
  parameter  int unsigned N            = 32,
  parameter  int unsigned LOAD_BUBBLES = 1,
  localparam int unsigned AW           = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          Flush,
  input  logic          InValid,
  output logic          InReady,
  input  logic [AW-1:0] RsAddr,
  input  logic [AW-1:0] RtAddr,
  input  logic [AW-1:0] DestAddrIn,
  input  logic          RegWriteIn,
  input  logic          MemReadIn,
  input  logic [N-1:0]  ImmIn,
  output logic [AW-1:0] Address1,
  output logic [AW-1:0] Address2,
  input  logic [N-1:0]  ReadData1,
  input  logic [N-1:0]  ReadData2,
  input  logic          WbWriteEnable,
  input  logic [AW-1:0] WbAddress,
  input  logic [N-1:0]  WbData,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [N-1:0]  OperandA,
  output logic [N-1:0]  OperandB,
  output logic [N-1:0]  ImmOut,
  output logic [AW-1:0] DestAddrOut,
  output logic          RegWriteOut,
  output logic          MemReadOut
);

  // The register file returns stale data in its write cycle, so snoop the write port.
  function automatic logic [N-1:0] sel_operand(input logic [AW-1:0] addr,
                                               input logic [N-1:0]  rf_data,
                                               input logic          wb_en,
                                               input logic [AW-1:0] wb_addr,
                                               input logic [N-1:0]  wb_data);
    if (addr == AW'(REG_ZERO)) return '0;
    if (wb_en && (wb_addr == addr)) return wb_data;
    return rf_data;
  endfunction

  logic         hazard;
  logic         accept;
  logic [N-1:0] operand_a;
  logic [N-1:0] operand_b;

  assign Address1  = RsAddr;
  assign Address2  = RtAddr;
  assign operand_a = sel_operand(RsAddr, ReadData1, WbWriteEnable, WbAddress, WbData);
  assign operand_b = sel_operand(RtAddr, ReadData2, WbWriteEnable, WbAddress, WbData);
  assign InReady   = Flush | ((~OutValid | OutReady) & ~hazard);
  assign accept    = InValid & InReady;

  load_interlock #(
    .AW          (AW),
    .LOAD_BUBBLES(LOAD_BUBBLES)
  ) u_interlock (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .Flush      (Flush),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .MemReadOut (MemReadOut),
    .DestAddrOut(DestAddrOut),
    .RsAddr     (RsAddr),
    .RtAddr     (RtAddr),
    .Hazard     (hazard)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      OutValid    <= 1'b0;
      OperandA    <= '0;
      OperandB    <= '0;
      ImmOut      <= '0;
      DestAddrOut <= '0;
      RegWriteOut <= 1'b0;
      MemReadOut  <= 1'b0;
    end else if (Flush) begin
      // Anything accepted during a flush is dropped.
      OutValid <= 1'b0;
    end else if (accept) begin
      OutValid    <= 1'b1;
      OperandA    <= operand_a;
      OperandB    <= operand_b;
      ImmOut      <= ImmIn;
      DestAddrOut <= DestAddrIn;
      RegWriteOut <= RegWriteIn;
      MemReadOut  <= MemReadIn;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench for decode_operand_stage: operand-select table plus handshake, interlock and flush sequences.
module tb_decode_operand_stage;

  localparam int unsigned N  = 32;
  localparam int unsigned AW = 5;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          Flush;
  logic          InValid;
  logic          InReady;
  logic [AW-1:0] RsAddr, RtAddr, DestAddrIn;
  logic          RegWriteIn, MemReadIn;
  logic [N-1:0]  ImmIn;
  logic [AW-1:0] Address1, Address2;
  logic [N-1:0]  ReadData1, ReadData2;
  logic          WbWriteEnable;
  logic [AW-1:0] WbAddress;
  logic [N-1:0]  WbData;
  logic          OutValid, OutReady;
  logic [N-1:0]  OperandA, OperandB, ImmOut;
  logic [AW-1:0] DestAddrOut;
  logic          RegWriteOut, MemReadOut;

  decode_operand_stage #(.N(N), .LOAD_BUBBLES(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .RsAddr(RsAddr), .RtAddr(RtAddr), .DestAddrIn(DestAddrIn),
    .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .ImmIn(ImmIn),
    .Address1(Address1), .Address2(Address2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WbWriteEnable(WbWriteEnable), .WbAddress(WbAddress), .WbData(WbData),
    .OutValid(OutValid), .OutReady(OutReady),
    .OperandA(OperandA), .OperandB(OperandB), .ImmOut(ImmOut),
    .DestAddrOut(DestAddrOut), .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [AW-1:0] rs, rt, wba, dest;
    logic [N-1:0]  rd1, rd2, wbd, imm;
    logic          wbe, regw;
    logic [N-1:0]  ea, eb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic present(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] dest, input logic [N-1:0] rd1,
                         input logic [N-1:0] rd2, input logic [N-1:0] imm,
                         input logic memr);
    InValid       = 1'b1;
    RsAddr        = rs;
    RtAddr        = rt;
    DestAddrIn    = dest;
    ReadData1     = rd1;
    ReadData2     = rd2;
    ImmIn         = imm;
    MemReadIn     = memr;
    RegWriteIn    = 1'b1;
    WbWriteEnable = 1'b0;
    WbAddress     = '0;
    WbData        = '0;
  endtask

  task automatic idle();
    InValid   = 1'b0;
    MemReadIn = 1'b0;
    RsAddr    = '0;
    RtAddr    = '0;
  endtask

  // Ticks until the instruction tagged via ImmIn is on the outputs, counting empty cycles.
  task automatic wait_tag(input logic [N-1:0] tag, output int bubbles, output bit found);
    bubbles = 0;
    found   = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (OutValid && ImmOut == tag) found = 1'b1;
      else if (!OutValid) bubbles++;
    end
  endtask

  int bub;
  bit found;

  initial begin
    vecs[0] = '{rs:3,  rt:4,  wba:0,  dest:10, rd1:32'h11,       rd2:32'h22,       wbd:32'h0,      imm:32'h100, wbe:0, regw:1, ea:32'h11,       eb:32'h22};
    vecs[1] = '{rs:0,  rt:4,  wba:0,  dest:11, rd1:32'hDEAD,     rd2:32'h22,       wbd:32'h77,     imm:32'h101, wbe:1, regw:0, ea:32'h0,        eb:32'h22};
    vecs[2] = '{rs:6,  rt:5,  wba:5,  dest:12, rd1:32'h66,       rd2:32'h99,       wbd:32'h55,     imm:32'h102, wbe:1, regw:1, ea:32'h66,       eb:32'h55};
    vecs[3] = '{rs:5,  rt:5,  wba:5,  dest:13, rd1:32'h1,        rd2:32'h2,        wbd:32'hABCD,   imm:32'h103, wbe:1, regw:0, ea:32'hABCD,     eb:32'hABCD};
    vecs[4] = '{rs:9,  rt:0,  wba:9,  dest:14, rd1:32'h90,       rd2:32'hBEEF,     wbd:32'h1234,   imm:32'h104, wbe:1, regw:1, ea:32'h1234,     eb:32'h0};
    vecs[5] = '{rs:31, rt:30, wba:31, dest:31, rd1:32'hFFFFFFFF, rd2:32'h80000000, wbd:32'h5,      imm:32'hFFFFFFFF, wbe:0, regw:0, ea:32'hFFFFFFFF, eb:32'h80000000};
    vecs[6] = '{rs:10, rt:11, wba:12, dest:1,  rd1:32'hA0,       rd2:32'hB0,       wbd:32'hC0,     imm:32'h106, wbe:1, regw:1, ea:32'hA0,       eb:32'hB0};

    RESET_N = 1'b0;
    Flush = 1'b0; OutReady = 1'b1;
    present('0, '0, '0, '0, '0, '0, 1'b0);
    idle();
    tick(); tick();
    RESET_N = 1'b1;
    #1;
    chk("reset OutValid", 32'(OutValid), 32'h0);
    chk("reset OperandA", OperandA, 32'h0);
    chk("reset OperandB", OperandB, 32'h0);
    chk("reset ImmOut", ImmOut, 32'h0);
    chk("reset DestAddrOut", 32'(DestAddrOut), 32'h0);
    chk("reset ctrl", {30'h0, RegWriteOut, MemReadOut}, 32'h0);
    chk("reset InReady", 32'(InReady), 32'h1);

    // Operand select table, full throughput
    for (int i = 0; i < 7; i++) begin
      present(vecs[i].rs, vecs[i].rt, vecs[i].dest, vecs[i].rd1, vecs[i].rd2, vecs[i].imm, 1'b0);
      RegWriteIn = vecs[i].regw;
      WbWriteEnable = vecs[i].wbe;
      WbAddress = vecs[i].wba;
      WbData = vecs[i].wbd;
      #1;
      chk($sformatf("v%0d Address1", i), 32'(Address1), 32'(vecs[i].rs));
      chk($sformatf("v%0d Address2", i), 32'(Address2), 32'(vecs[i].rt));
      chk($sformatf("v%0d InReady", i), 32'(InReady), 32'h1);
      tick();
      chk($sformatf("v%0d OutValid", i), 32'(OutValid), 32'h1);
      chk($sformatf("v%0d OperandA", i), OperandA, vecs[i].ea);
      chk($sformatf("v%0d OperandB", i), OperandB, vecs[i].eb);
      chk($sformatf("v%0d ImmOut", i), ImmOut, vecs[i].imm);
      chk($sformatf("v%0d DestAddrOut", i), 32'(DestAddrOut), 32'(vecs[i].dest));
      chk($sformatf("v%0d RegWriteOut", i), 32'(RegWriteOut), 32'(vecs[i].regw));
      chk($sformatf("v%0d MemReadOut", i), 32'(MemReadOut), 32'h0);
    end

    // Downstream stall for 3 cycles
    present(5'd3, 5'd2, 5'd20, 32'h33, 32'h2, 32'h30, 1'b0);
    tick();
    chk("stall X OperandA", OperandA, 32'h33);
    OutReady = 1'b0;
    present(5'd4, 5'd2, 5'd21, 32'h44, 32'h2, 32'h31, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d InReady", i), 32'(InReady), 32'h0);
      tick();
      chk($sformatf("stall%0d OutValid", i), 32'(OutValid), 32'h1);
      chk($sformatf("stall%0d OperandA", i), OperandA, 32'h33);
      chk($sformatf("stall%0d ImmOut", i), ImmOut, 32'h30);
    end
    OutReady = 1'b1;
    #1;
    chk("unstall InReady", 32'(InReady), 32'h1);
    tick();
    chk("unstall Y OperandA", OperandA, 32'h44);
    chk("unstall Y ImmOut", ImmOut, 32'h31);
    idle();
    tick();
    chk("drain OutValid", 32'(OutValid), 32'h0);
    tick(); tick();

    // Dependent on a load: two bubbles
    present(5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 32'h201, 1'b1);
    tick();
    chk("ld1 on output", ImmOut, 32'h201);
    present(5'd7, 5'd2, 5'd8, 32'h70, 32'h2, 32'h202, 1'b0);
    wait_tag(32'h202, bub, found);
    chk("dep seen", 32'(found), 32'h1);
    chk("dep bubbles", 32'(bub), 32'h2);
    chk("dep OperandA", OperandA, 32'h70);
    idle();
    tick(); tick(); tick();

    // Independent of a load: no bubble
    present(5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 32'h211, 1'b1);
    tick();
    present(5'd8, 5'd9, 5'd3, 32'h80, 32'h90, 32'h212, 1'b0);
    wait_tag(32'h212, bub, found);
    chk("indep seen", 32'(found), 32'h1);
    chk("indep bubbles", 32'(bub), 32'h0);
    idle();
    tick(); tick(); tick();

    // Back-to-back loads to the same register each interlock
    present(5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 32'h221, 1'b1);
    tick();
    present(5'd7, 5'd2, 5'd7, 32'h7, 32'h2, 32'h222, 1'b1);
    wait_tag(32'h222, bub, found);
    chk("ld2 seen", 32'(found), 32'h1);
    chk("ld2 bubbles", 32'(bub), 32'h2);
    present(5'd3, 5'd7, 5'd4, 32'h3, 32'h7, 32'h223, 1'b0);
    wait_tag(32'h223, bub, found);
    chk("ld2 dep seen", 32'(found), 32'h1);
    chk("ld2 dep bubbles", 32'(bub), 32'h2);
    idle();
    tick(); tick(); tick();

    // Asynchronous reset mid-operation
    present(5'd2, 5'd3, 5'd6, 32'h5A, 32'h3, 32'h50, 1'b0);
    tick();
    chk("pre-arst OutValid", 32'(OutValid), 32'h1);
    idle();
    #1;
    RESET_N = 1'b0;
    #1;
    chk("arst OutValid", 32'(OutValid), 32'h0);
    chk("arst OperandA", OperandA, 32'h0);
    chk("arst ImmOut", ImmOut, 32'h0);
    #1;
    RESET_N = 1'b1;
    tick();

    // Flush a stalled load while the interlock is open
    present(5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 32'h61, 1'b1);
    #1;
    chk("fl L1 InReady", 32'(InReady), 32'h1);
    tick();
    present(5'd1, 5'd2, 5'd9, 32'h1, 32'h2, 32'h62, 1'b1);
    #1;
    chk("fl L2 InReady", 32'(InReady), 32'h1);
    tick();
    chk("fl L2 on output", ImmOut, 32'h62);
    OutReady = 1'b0;
    present(5'd7, 5'd9, 5'd4, 32'h7, 32'h9, 32'h63, 1'b0);
    #1;
    chk("fl pre InReady", 32'(InReady), 32'h0);
    Flush = 1'b1;
    #1;
    chk("fl InReady", 32'(InReady), 32'h1);
    tick();
    Flush = 1'b0;
    idle();
    RsAddr = 5'd9;
    RtAddr = 5'd7;
    #1;
    chk("post-fl OutValid", 32'(OutValid), 32'h0);
    chk("post-fl InReady", 32'(InReady), 32'h1);
    OutReady = 1'b1;
    tick();
    chk("post-fl discard", 32'(OutValid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
